// File: rtl/i2c_target.sv
// I2C target with fixed 7-bit address, oversampled on clk.
// Writes are delivered one byte at a time; reads pull bytes through tx_req/tx_data.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       nack_seen
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_RX        = 3'd3;
  localparam logic [2:0] S_RX_ACK    = 3'd4;
  localparam logic [2:0] S_TX        = 3'd5;
  localparam logic [2:0] S_TX_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic       scl_rise_reg, scl_fall_reg;
  logic       start_reg, stop_reg;

  logic [2:0] state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       sda_oe_reg;
  logic       ack_phase_reg;
  logic       rw_reg;
  logic       load_tx;

  // Open-drain: reset releases the line combinationally, without waiting for an edge.
  assign sda = (sda_oe_reg && !rst) ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus a history flop; strobes are registered so every
  // pin edge reaches the FSM three clocks later.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1       <= 1'b1;
      scl_s2       <= 1'b1;
      scl_h        <= 1'b1;
      sda_s1       <= 1'b1;
      sda_s2       <= 1'b1;
      sda_h        <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_s1       <= scl;
      scl_s2       <= scl_s1;
      scl_h        <= scl_s2;
      sda_s1       <= sda;
      sda_s2       <= sda_s1;
      sda_h        <= sda_s2;
      scl_rise_reg <= scl_s2 & ~scl_h;
      scl_fall_reg <= ~scl_s2 & scl_h;
      start_reg    <= ~sda_s2 & sda_h & scl_s2 & scl_h;
      stop_reg     <= sda_s2 & ~sda_h & scl_s2 & scl_h;
    end
  end

  // A new read byte is consumed on the scl_fall that ends an ACK slot; in TX_ACK
  // ack_phase_reg means the master's ACK has already been sampled.
  always_comb begin
    load_tx = 1'b0;
    if (!start_reg && !stop_reg && scl_fall_reg && ack_phase_reg) begin
      if (state_reg == S_ADDR_ACK && rw_reg)
        load_tx = 1'b1;
      else if (state_reg == S_TX_ACK)
        load_tx = 1'b1;
    end
  end

  assign tx_req = load_tx & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      sda_oe_reg    <= 1'b0;
      ack_phase_reg <= 1'b0;
      rw_reg        <= 1'b0;
      busy          <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      nack_seen     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      nack_seen <= 1'b0;
      if (start_reg) begin
        state_reg     <= S_ADDR;
        bit_cnt_reg   <= 3'd0;
        sda_oe_reg    <= 1'b0;
        ack_phase_reg <= 1'b0;
        busy          <= 1'b0;
      end else if (stop_reg) begin
        state_reg     <= S_IDLE;
        sda_oe_reg    <= 1'b0;
        ack_phase_reg <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state_reg)
          S_ADDR: begin
            if (scl_rise_reg) begin
              shift_reg   <= {shift_reg[6:0], sda_s2};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                if (shift_reg[6:0] == ADDR) begin
                  rw_reg        <= sda_s2;
                  ack_phase_reg <= 1'b0;
                  busy          <= 1'b1;
                  state_reg     <= S_ADDR_ACK;
                end else begin
                  state_reg <= S_WAIT_STOP;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall_reg) begin
              if (!ack_phase_reg) begin
                sda_oe_reg    <= 1'b1;
                ack_phase_reg <= 1'b1;
              end else begin
                bit_cnt_reg   <= 3'd0;
                ack_phase_reg <= 1'b0;
                if (rw_reg) begin
                  shift_reg  <= tx_data;
                  sda_oe_reg <= ~tx_data[7];
                  state_reg  <= S_TX;
                end else begin
                  sda_oe_reg <= 1'b0;
                  state_reg  <= S_RX;
                end
              end
            end
          end
          S_RX: begin
            if (scl_rise_reg) begin
              shift_reg   <= {shift_reg[6:0], sda_s2};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                rx_data       <= {shift_reg[6:0], sda_s2};
                rx_valid      <= 1'b1;
                ack_phase_reg <= 1'b0;
                state_reg     <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall_reg) begin
              if (!ack_phase_reg) begin
                sda_oe_reg    <= 1'b1;
                ack_phase_reg <= 1'b1;
              end else begin
                sda_oe_reg    <= 1'b0;
                ack_phase_reg <= 1'b0;
                bit_cnt_reg   <= 3'd0;
                state_reg     <= S_RX;
              end
            end
          end
          S_TX: begin
            if (scl_fall_reg) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                sda_oe_reg    <= 1'b0;
                ack_phase_reg <= 1'b0;
                state_reg     <= S_TX_ACK;
              end else begin
                shift_reg  <= {shift_reg[6:0], 1'b0};
                sda_oe_reg <= ~shift_reg[6];
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise_reg && !ack_phase_reg) begin
              if (sda_s2) begin
                nack_seen <= 1'b1;
                state_reg <= S_WAIT_STOP;
              end else begin
                ack_phase_reg <= 1'b1;
              end
            end else if (scl_fall_reg && ack_phase_reg) begin
              shift_reg     <= tx_data;
              sda_oe_reg    <= ~tx_data[7];
              bit_cnt_reg   <= 3'd0;
              ack_phase_reg <= 1'b0;
              state_reg     <= S_TX;
            end
          end
          S_WAIT_STOP: begin
            sda_oe_reg <= 1'b0;
          end
          default: begin
            sda_oe_reg <= 1'b0;
            state_reg  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
